// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Two writeback sources (A = ALU, B = memory load) share the single register
// file write port. Each source feeds a small FIFO. A round-robin arbiter pops
// at most one head per cycle into a registered write port. A pending-write
// mask covers every queued or in-flight destination so hazard logic can stall.
module regfile_wr_arbiter #(
   parameter int DEPTH    = 2,
   parameter bit DROP_R31 = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        aValid,
   output logic        aReady,
   input  logic [4:0]  aAddr,
   input  logic [63:0] aData,
   input  logic        bValid,
   output logic        bReady,
   input  logic [4:0]  bAddr,
   input  logic [63:0] bData,
   output logic        rfWrite,
   output logic [4:0]  rfWrAddr,
   output logic [63:0] rfWrData,
   output logic [31:0] pending,
   output logic        idle
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

   // Index 0 is source A, index 1 is source B throughout.
   logic [1:0]    w_in_valid;
   logic [4:0]    w_in_addr [2];
   logic [63:0]   w_in_data [2];
   logic [1:0]    w_full;
   logic [1:0]    w_ready;
   logic [1:0]    w_push;
   logic [1:0]    w_grant;
   logic [4:0]    w_head_addr;
   logic [63:0]   w_head_data;
   logic [31:0]   w_pending;

   logic [4:0]    r_mem_addr [2][DEPTH];
   logic [63:0]   r_mem_data [2][DEPTH];
   logic [PW-1:0] r_wr_ptr [2];
   logic [PW-1:0] r_rd_ptr [2];
   logic [CW-1:0] r_count [2];
   src_e          r_last_grant;
   logic          r_rf_write;
   logic [4:0]    r_rf_addr;
   logic [63:0]   r_rf_data;

   assign w_in_valid   = {bValid, aValid};
   assign w_in_addr[0] = aAddr;
   assign w_in_addr[1] = bAddr;
   assign w_in_data[0] = aData;
   assign w_in_data[1] = bData;

   // Handshake: ready depends only on reset and FIFO occupancy, never on valid.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      w_full  = '0;
      w_ready = '0;
      w_push  = '0;
      for (int s = 0; s < 2; s++) begin
         w_full[s]  = (r_count[s] == CW'(DEPTH));
         w_ready[s] = !rst && !w_full[s];
         // Writes to XZR complete the handshake but are never stored.
         w_push[s]  = w_in_valid[s] && w_ready[s] &&
                      !(DROP_R31 && (w_in_addr[s] == 5'd31));
      end
   end

   assign aReady = w_ready[0];
   assign bReady = w_ready[1];

   // Round-robin grant: a lone non-empty FIFO wins, a tie goes to the source not granted last.
   always_comb begin
      w_grant     = '0;
      w_head_addr = '0;
      w_head_data = '0;
      if (r_count[0] != '0 && (r_count[1] == '0 || r_last_grant == SRC_B)) begin
         w_grant[0] = 1'b1;
      end else if (r_count[1] != '0) begin
         w_grant[1] = 1'b1;
      end
      if (w_grant[0]) begin
         w_head_addr = r_mem_addr[0][r_rd_ptr[0]];
         w_head_data = r_mem_data[0][r_rd_ptr[0]];
      end else if (w_grant[1]) begin
         w_head_addr = r_mem_addr[1][r_rd_ptr[1]];
         w_head_data = r_mem_data[1][r_rd_ptr[1]];
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            r_wr_ptr[s] <= '0;
            r_rd_ptr[s] <= '0;
            r_count[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (w_push[s])  r_wr_ptr[s] <= r_wr_ptr[s] + PW'(1);
            if (w_grant[s]) r_rd_ptr[s] <= r_rd_ptr[s] + PW'(1);
            if (w_push[s] && !w_grant[s])      r_count[s] <= r_count[s] + CW'(1);
            else if (!w_push[s] && w_grant[s]) r_count[s] <= r_count[s] - CW'(1);
         end
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; entries are only read when the count marks them valid.
      for (int s = 0; s < 2; s++) begin
         if (w_push[s]) begin
            r_mem_addr[s][r_wr_ptr[s]] <= w_in_addr[s];
            r_mem_data[s][r_wr_ptr[s]] <= w_in_data[s];
         end
      end
   end

   // Registered write port and round-robin history; addr/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rf_write   <= 1'b0;
         r_rf_addr    <= '0;
         r_rf_data    <= '0;
         r_last_grant <= SRC_B;
      end else begin
         r_rf_write <= |w_grant;
         if (|w_grant) begin
            r_rf_addr <= w_head_addr;
            r_rf_data <= w_head_data;
         end
         if (w_grant[0])      r_last_grant <= SRC_A;
         else if (w_grant[1]) r_last_grant <= SRC_B;
      end
   end

   // Pending mask: every valid FIFO entry plus the write currently on the port.
   always_comb begin
      logic [PW-1:0] w_off;
      w_off     = '0;
      w_pending = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            // Distance from the read pointer, modulo DEPTH; valid if below the count.
            w_off = PW'(i) - r_rd_ptr[s];
            if (CW'(w_off) < r_count[s]) w_pending[r_mem_addr[s][i]] = 1'b1;
         end
      end
      if (r_rf_write) w_pending[r_rf_addr] = 1'b1;
   end

   assign rfWrite  = r_rf_write;
   assign rfWrAddr = r_rf_addr;
   assign rfWrData = r_rf_data;
   assign pending  = w_pending;
   assign idle     = (r_count[0] == '0) && (r_count[1] == '0) && !r_rf_write;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus randomized
// streaming, checked by a queue-level reference model and a scoreboard.
module tb_regfile_wr_arbiter;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [4:0]  addr;
      logic [63:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [63:0] a_data, b_data;
   logic        rf_write;
   logic [4:0]  rf_addr;
   logic [63:0] rf_data;
   logic [31:0] pending;
   logic        idle;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: per-source queues and the write port contents.
   wr_t         qa[$];
   wr_t         qb[$];
   wr_t         exp_q[$];
   logic        m_rf;
   logic [4:0]  m_addr;
   logic [63:0] m_data;
   bit          m_last_b;
   bit          mon_en = 1'b0;
   bit          m_rdy_a, m_rdy_b, m_gnt_a, m_gnt_b;
   wr_t         m_e;
   wr_t         mon_e;

   logic [4:0]  obs_q[$];
   int          ready_low_a, ready_low_b;
   wr_t         items_a[$];
   wr_t         items_b[$];

   regfile_wr_arbiter #(.DEPTH(DEPTH), .DROP_R31(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .aValid   (a_valid),
      .aReady   (a_ready),
      .aAddr    (a_addr),
      .aData    (a_data),
      .bValid   (b_valid),
      .bReady   (b_ready),
      .bAddr    (b_addr),
      .bData    (b_data),
      .rfWrite  (rf_write),
      .rfWrAddr (rf_addr),
      .rfWrData (rf_data),
      .pending  (pending),
      .idle     (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic wr_t mk(input logic [4:0] a, input logic [63:0] d);
      wr_t r;
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   function automatic logic [31:0] model_pending();
      logic [31:0] p;
      p = '0;
      foreach (qa[i]) p[qa[i].addr] = 1'b1;
      foreach (qb[i]) p[qb[i].addr] = 1'b1;
      if (m_rf) p[m_addr] = 1'b1;
      return p;
   endfunction

   // Reference model: ready from occupancy before the edge, one pop by round-robin, then accept.
   always @(posedge clk) begin
      if (rst) begin
         qa.delete();
         qb.delete();
         exp_q.delete();
         m_rf     = 1'b0;
         m_addr   = '0;
         m_data   = '0;
         m_last_b = 1'b1;
         mon_en   = 1'b1;
      end else begin
         m_rdy_a = (qa.size() < DEPTH);
         m_rdy_b = (qb.size() < DEPTH);
         m_gnt_a = (qa.size() != 0) && ((qb.size() == 0) || m_last_b);
         m_gnt_b = (qb.size() != 0) && !m_gnt_a;
         m_rf    = m_gnt_a || m_gnt_b;
         if (m_gnt_a) begin
            m_e = qa.pop_front();
            m_last_b = 1'b0;
         end else if (m_gnt_b) begin
            m_e = qb.pop_front();
            m_last_b = 1'b1;
         end
         if (m_rf) begin
            m_addr = m_e.addr;
            m_data = m_e.data;
            exp_q.push_back(m_e);
         end
         if (a_valid && m_rdy_a && a_addr != 5'd31) qa.push_back(mk(a_addr, a_data));
         if (b_valid && m_rdy_b && b_addr != 5'd31) qb.push_back(mk(b_addr, b_data));
      end
   end

   // Monitor: compares DUT outputs mid-cycle against the model and scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         check("a_ready", a_ready, (!rst && qa.size() < DEPTH));
         check("b_ready", b_ready, (!rst && qb.size() < DEPTH));
         if (!rst && !a_ready) ready_low_a++;
         if (!rst && !b_ready) ready_low_b++;
         check("rf_write", rf_write, m_rf);
         if (rf_write === 1'b1) begin
            check("sb_entry_present", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("rf_addr", rf_addr, mon_e.addr);
               check("rf_data", rf_data, mon_e.data);
            end
            obs_q.push_back(rf_addr);
         end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
         check("rf_addr_hold", rf_addr, m_addr);
         check("rf_data_hold", rf_data, m_data);
         check("pending", pending, model_pending());
         check("idle", idle, (qa.size() == 0 && qb.size() == 0 && !m_rf));
      end
   end

   task automatic set_src(input int s, input logic v, input wr_t e);
      if (s == 0) begin
         a_valid = v; a_addr = e.addr; a_data = e.data;
      end else begin
         b_valid = v; b_addr = e.addr; b_data = e.data;
      end
   endtask

   // Drives one source's item list; entered and left just after a rising edge.
   task automatic drive(input int s, input int max_gap);
      int  n;
      int  t;
      bit  fired;
      wr_t e;
      n = (s == 0) ? items_a.size() : items_b.size();
      for (int i = 0; i < n; i++) begin
         e = (s == 0) ? items_a[i] : items_b[i];
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
         end
         set_src(s, 1'b1, e);
         t = 0;
         fired = 1'b0;
         while (!fired && t < 50) begin
            @(negedge clk);
            fired = (s == 0) ? a_ready : b_ready;
            @(posedge clk);
            #1;
            t++;
         end
         check("hs_timeout", fired, 1'b1);
         set_src(s, 1'b0, e);
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         done = (idle === 1'b1) && (exp_q.size() == 0) && (qa.size() == 0) && (qb.size() == 0);
      end
      check("drain_timeout", done, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [4:0] exp3 [8];
      exp3 = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
      rst = 1'b1;
      set_src(0, 1'b0, '0);
      set_src(1, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single write from A: one cycle on the port, pending tracked by the monitor.
      obs_q.delete();
      items_a.delete();
      items_a.push_back(mk(5'd8, 64'hAAAAAAAAAAAAAAAA));
      drive(0, 0);
      wait_idle();
      check("t1_count", obs_q.size(), 1);
      if (obs_q.size() > 0) check("t1_addr", obs_q[0], 5'd8);

      // Simultaneous A and B from reset: A wins the first tie.
      do_reset();
      obs_q.delete();
      items_a.delete();
      items_b.delete();
      items_a.push_back(mk(5'd0, 64'hFFFAFFFFFFFFFFFF));
      items_b.push_back(mk(5'd15, 64'hCCCCCCCCCCCCCCCC));
      fork
         drive(0, 0);
         drive(1, 0);
      join
      wait_idle();
      check("t2_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("t2_first", obs_q[0], 5'd0);
         check("t2_second", obs_q[1], 5'd15);
      end

      // Both sources stream four writes: strict alternation, FIFOs fill up.
      do_reset();
      obs_q.delete();
      ready_low_a = 0;
      ready_low_b = 0;
      items_a.delete();
      items_b.delete();
      for (int i = 0; i < 4; i++) begin
         items_a.push_back(mk(5'(1 + i), {32'hA0A0A0A0, 32'(i)}));
         items_b.push_back(mk(5'(11 + i), {32'hB0B0B0B0, 32'(i)}));
      end
      fork
         drive(0, 0);
         drive(1, 0);
      join
      wait_idle();
      check("t3_count", obs_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < obs_q.size()) check("t3_order", obs_q[i], exp3[i]);
      end
      check("t3_a_backpressure", (ready_low_a > 0), 1'b1);
      check("t3_b_backpressure", (ready_low_b > 0), 1'b1);

      // Write to XZR: handshaken, never reaches the port.
      obs_q.delete();
      items_a.delete();
      items_a.push_back(mk(5'd31, 64'hF0F0F0F0F0F0F0F0));
      drive(0, 0);
      repeat (4) @(posedge clk);
      #1;
      check("t4_no_write", obs_q.size(), 0);
      check("t4_idle", idle, 1'b1);

      // Reset with writes queued: everything discarded.
      do_reset();
      items_a.delete();
      items_b.delete();
      for (int i = 0; i < 2; i++) begin
         items_a.push_back(mk(5'(3 + i), {$urandom(), $urandom()}));
         items_b.push_back(mk(5'(20 + i), {$urandom(), $urandom()}));
      end
      fork
         drive(0, 0);
         drive(1, 0);
      join
      do_reset();
      obs_q.delete();
      @(negedge clk);
      check("t5_rf_write", rf_write, 1'b0);
      check("t5_pending", pending, 32'h0);
      check("t5_idle", idle, 1'b1);
      check("t5_a_ready", a_ready, 1'b1);
      check("t5_b_ready", b_ready, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("t5_no_writes", obs_q.size(), 0);

      // Same address twice from A: order kept.
      obs_q.delete();
      items_a.delete();
      items_a.push_back(mk(5'd15, 64'h1111111111111111));
      items_a.push_back(mk(5'd15, 64'h2222222222222222));
      drive(0, 0);
      wait_idle();
      check("t6_count", obs_q.size(), 2);

      // Randomized streaming from both sources, including XZR and gaps.
      for (int r = 0; r < 4; r++) begin
         items_a.delete();
         items_b.delete();
         for (int i = 0; i < 40; i++) begin
            items_a.push_back(mk(5'($urandom_range(0, 31)), {$urandom(), $urandom()}));
            items_b.push_back(mk(5'($urandom_range(0, 31)), {$urandom(), $urandom()}));
         end
         fork
            drive(0, r);
            drive(1, 3 - r);
         join
         wait_idle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
